// File: rtl/dmem_responder.sv
// Data-memory responder for the core's LD/ST handshake: one request in flight,
// fixed-latency word/byte access to internal storage, response held until acked.
package dmem_pkg;
    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;
endpackage

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     from_core_i,
    input  logic [31:0] addr_i,
    output mem_out_s    to_core_o,
    output logic        misalign_o
);

    localparam int depth_lp = 2 ** addr_width_p;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e                  state, state_next;
    logic                    accept;
    logic [3:0]              count;
    logic [addr_width_p-1:0] idx, idx_q;
    logic [1:0]              lane, lane_q;
    logic                    wen_q, byte_q;
    logic [31:0]             mem [depth_lp];
    logic [31:0]             word;
    logic [7:0]              lane_byte;

    // Bits above the word index are dropped, so the address space wraps.
    assign idx  = addr_i[2 +: addr_width_p];
    assign lane = addr_i[1:0];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                accept = from_core_i.valid && reset;
                if (accept) state_next = (latency_p == 1) ? RESP : BUSY;
            end
            BUSY:    if (count <= 4'd1) state_next = RESP;
            RESP:    if (from_core_i.yumi) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= 4'd0;
            misalign_o <= 1'b0;
            idx_q      <= '0;
            lane_q     <= 2'd0;
            wen_q      <= 1'b0;
            byte_q     <= 1'b0;
        end else begin
            state      <= state_next;
            misalign_o <= accept && !from_core_i.byte_not_word && (lane != 2'd0);
            if (accept) begin
                count  <= 4'(latency_p - 1);
                idx_q  <= idx;
                lane_q <= lane;
                wen_q  <= from_core_i.wen;
                byte_q <= from_core_i.byte_not_word;
            end else if (state == BUSY) begin
                count <= count - 4'd1;
            end
        end
    end

    // NOTE: storage has no reset; only control state returns to a known value.
    always_ff @(posedge clk) begin
        if (accept && from_core_i.wen) begin
            if (from_core_i.byte_not_word)
                mem[idx][{lane, 3'b000} +: 8] <= from_core_i.write_data[7:0];
            else
                mem[idx] <= from_core_i.write_data;
        end
    end

    // The store commits at acceptance, so reads in RESP already see it.
    assign word      = mem[idx_q];
    assign lane_byte = word[{lane_q, 3'b000} +: 8];

    always_comb begin
        to_core_o      = '0;
        to_core_o.yumi = accept;
        if (state == RESP) begin
            to_core_o.valid = 1'b1;
            if (wen_q)       to_core_o.read_data = 32'h0;
            else if (byte_q) to_core_o.read_data = {24'h0, lane_byte};
            else             to_core_o.read_data = word;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: latency-2 and latency-1 instances share stimulus;
// table-driven requests with a scoreboard, plus hold, overlap and reset sequences.
module tb_dmem_responder;
    import dmem_pkg::*;

    typedef struct {
        logic        wen;
        logic        bnw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_mis;
        int          hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    mem_in_s     from_core;
    logic [31:0] addr;
    mem_out_s    to_core, to_core1;
    logic        mis, mis1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    dmem_responder #(.addr_width_p(10), .latency_p(2)) dut (
        .clk(clk), .reset(reset), .from_core_i(from_core), .addr_i(addr),
        .to_core_o(to_core), .misalign_o(mis)
    );

    dmem_responder #(.addr_width_p(10), .latency_p(1)) dut1 (
        .clk(clk), .reset(reset), .from_core_i(from_core), .addr_i(addr),
        .to_core_o(to_core1), .misalign_o(mis1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(output logic [31:0] v);
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: response with no request outstanding");
            v = 'x;
        end else begin
            v = sb.pop_front();
        end
    endtask

    task automatic do_req(input int id, input vec_t v);
        logic [31:0] exp;
        int          n;
        @(negedge clk);
        from_core.valid         = 1'b1;
        from_core.wen           = v.wen;
        from_core.byte_not_word = v.bnw;
        from_core.write_data    = v.wdata;
        from_core.yumi          = 1'b0;
        addr                    = v.addr;
        #1;
        n = 0;
        while (!to_core.yumi && n < 16) begin
            @(negedge clk);
            #1;
            n++;
        end
        check($sformatf("v%0d accept_wait", id), 64'(n), 64'd0);
        check($sformatf("v%0d yumi1", id), 64'(to_core1.yumi), 64'd1);
        sb.push_back(v.exp_data);
        // c+1: latency-1 instance responds, misalign pulse visible
        @(negedge clk);
        from_core.valid = 1'b0;
        check($sformatf("v%0d misalign", id), 64'(mis), 64'(v.exp_mis));
        check($sformatf("v%0d misalign1", id), 64'(mis1), 64'(v.exp_mis));
        check($sformatf("v%0d early_valid", id), 64'(to_core.valid), 64'd0);
        check($sformatf("v%0d valid1", id), 64'(to_core1.valid), 64'd1);
        check($sformatf("v%0d data1", id), 64'(to_core1.read_data), 64'(v.exp_data));
        // c+2: latency-2 instance responds
        @(negedge clk);
        sb_pop(exp);
        check($sformatf("v%0d valid", id), 64'(to_core.valid), 64'd1);
        check($sformatf("v%0d data", id), 64'(to_core.read_data), 64'(exp));
        check($sformatf("v%0d misalign_end", id), 64'({mis, mis1}), 64'd0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check($sformatf("v%0d hold%0d valid", id, h), 64'({to_core.valid, to_core1.valid}), 64'd3);
            check($sformatf("v%0d hold%0d data", id, h), 64'(to_core.read_data), 64'(exp));
            check($sformatf("v%0d hold%0d data1", id, h), 64'(to_core1.read_data), 64'(v.exp_data));
        end
        from_core.yumi = 1'b1;
        @(negedge clk);
        from_core.yumi = 1'b0;
        check($sformatf("v%0d after_ack", id), 64'({to_core.valid, to_core1.valid}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [$];
        logic [31:0] exp;

        //                wen   bnw   addr          wdata         exp_data      mis  hold
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 32'h0000_0013, 32'h1234_56AB, 32'h0000_0000, 1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hABAD_BEEF, 1'b0, 5});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h0000_0012, 32'h0000_0000, 32'h0000_00AD, 1'b0, 0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h0000_0024, 32'h0BAD_F00D, 32'h0000_0000, 1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0000_0025, 32'h0000_0000, 32'h0BAD_F00D, 1'b1, 0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h0000_0027, 32'h0000_0000, 32'h0000_000B, 1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h0000_0024, 32'h0000_0000, 32'h0000_000D, 1'b0, 1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h0000_1010, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h0000_0032, 32'h1122_3344, 32'h0000_0000, 1'b1, 0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0000_0030, 32'h0000_0000, 32'h1122_3344, 1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h0000_1013, 32'h0000_0000, 32'h0000_00CA, 1'b0, 0});

        reset     = 1'b0;
        from_core = '0;
        addr      = 32'h0;
        repeat (3) @(negedge clk);
        from_core.valid = 1'b1;
        #1;
        check("reset to_core", 64'(to_core), 64'd0);
        check("reset to_core1", 64'(to_core1), 64'd0);
        check("reset misalign", 64'({mis, mis1}), 64'd0);
        from_core.valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) do_req(i, vecs[i]);

        // Valid held high through BUSY/RESP: exactly one new accept, the cycle after ack.
        @(negedge clk);
        from_core.valid         = 1'b1;
        from_core.wen           = 1'b0;
        from_core.byte_not_word = 1'b0;
        from_core.yumi          = 1'b0;
        addr                    = 32'h0000_0024;
        #1;
        check("ovl accept", 64'({to_core.yumi, to_core1.yumi}), 64'd3);
        sb.push_back(32'h0BAD_F00D);
        @(negedge clk);
        #1;
        check("ovl busy_yumi", 64'({to_core.yumi, to_core1.yumi}), 64'd0);
        @(negedge clk);
        #1;
        sb_pop(exp);
        check("ovl resp_yumi", 64'({to_core.yumi, to_core1.yumi}), 64'd0);
        check("ovl valid", 64'(to_core.valid), 64'd1);
        check("ovl data", 64'(to_core.read_data), 64'(exp));
        @(negedge clk);
        #1;
        check("ovl hold_yumi", 64'({to_core.yumi, to_core1.yumi}), 64'd0);
        from_core.yumi = 1'b1;
        @(negedge clk);
        from_core.yumi = 1'b0;
        #1;
        check("ovl reaccept", 64'({to_core.yumi, to_core1.yumi}), 64'd3);
        check("ovl reaccept_valid", 64'({to_core.valid, to_core1.valid}), 64'd0);
        sb.push_back(32'h0BAD_F00D);
        @(negedge clk);
        #1;
        check("ovl single_accept", 64'({to_core.yumi, to_core1.yumi}), 64'd0);
        from_core.valid = 1'b0;
        @(negedge clk);
        sb_pop(exp);
        check("ovl2 valid", 64'(to_core.valid), 64'd1);
        check("ovl2 data", 64'(to_core.read_data), 64'(exp));
        from_core.yumi = 1'b1;
        @(negedge clk);
        from_core.yumi = 1'b0;
        check("ovl2 after_ack", 64'({to_core.valid, to_core1.valid}), 64'd0);

        // Reset during BUSY drops the response but keeps the committed store.
        @(negedge clk);
        from_core.valid         = 1'b1;
        from_core.wen           = 1'b1;
        from_core.byte_not_word = 1'b0;
        from_core.write_data    = 32'h1234_5678;
        addr                    = 32'h0000_0020;
        #1;
        check("rst_mid accept", 64'(to_core.yumi), 64'd1);
        @(negedge clk);
        from_core.valid = 1'b0;
        reset           = 1'b0;
        @(negedge clk);
        check("rst_mid to_core", 64'(to_core), 64'd0);
        check("rst_mid to_core1", 64'(to_core1), 64'd0);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rst_mid no_valid%0d", k), 64'({to_core.valid, to_core1.valid}), 64'd0);
        end
        do_req(100, vec_t'{1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 1'b0, 0});

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
